// File: rtl/ifu_fetch_ctrl.sv
// Producer side of the IFU fetch FIFO: owns the fetch PC, issues sequential imem
// requests, pushes responses and credit-tracks FIFO occupancy plus in-flight requests.
module ifu_fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    output logic        o_fifo_push,
    output logic [31:0] o_fifo_entry,
    output logic        o_fifo_flush,
    input  logic        i_fifo_pop,
    output logic        o_fifo_valid
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   r_fifo_cnt;
    logic [OUT_W-1:0]   r_outst;
    logic [OUT_W-1:0]   r_drop_cnt;
    logic               r_flush;

    logic               w_req_valid;
    logic               w_credit_ok;
    logic               w_outst_ok;
    logic               w_accept;
    logic               w_push;
    logic               w_fifo_valid;
    logic               w_pop;
    logic               w_drop;
    logic [OUT_W-1:0]   w_outst_nxt;

    // Credits cover both entries already in the FIFO and responses still in flight
    assign w_credit_ok  = (SUM_W'(r_fifo_cnt) + SUM_W'(r_outst)) < SUM_W'(FIFO_DEPTH);
    assign w_outst_ok   = r_outst < OUT_W'(MAX_OUTSTANDING);
    assign w_accept     = w_req_valid && i_imem_req_ready;
    assign w_push       = i_imem_resp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
    assign w_drop       = i_imem_resp_valid && (r_drop_cnt != '0);
    assign w_fifo_valid = (r_fifo_cnt != '0) && !i_redirect_valid && !r_flush;
    assign w_pop        = i_fifo_pop && w_fifo_valid;
    assign w_outst_nxt  = r_outst + OUT_W'(w_accept) - OUT_W'(i_imem_resp_valid);

    // Next state and request issue
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_req_valid = !i_redirect_valid && w_credit_ok && w_outst_ok;
            end
            S_DRAIN: begin
                if ((r_drop_cnt == '0) && !i_redirect_valid && !r_flush) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A redirect from any state goes through the flush cycle before fetching again
        if (i_redirect_valid) begin
            w_state_nxt = S_DRAIN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, credit counters and flush pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_fifo_cnt <= '0;
            r_outst    <= '0;
            r_drop_cnt <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= i_redirect_valid;
            r_outst <= w_outst_nxt;
            if (i_redirect_valid) begin
                r_pc       <= i_redirect_pc;
                r_fifo_cnt <= '0;
                r_drop_cnt <= w_outst_nxt;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - OUT_W'(1);
                end
            end
        end
    end

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = r_pc;
    assign o_fifo_push      = w_push;
    assign o_fifo_entry     = i_imem_resp_data;
    assign o_fifo_flush     = r_flush;
    assign o_fifo_valid     = w_fifo_valid;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a per-cycle vector table for fill, credit,
// redirect and saturation behaviour, then hand sequences for stall, reset and redirect.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] A = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        req_v;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        resp_v;
    logic [31:0] resp_d;
    logic        push;
    logic [31:0] entry;
    logic        flush;
    logic        pop;
    logic        fvalid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] raddr;
        logic        pop;
        logic        redir;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] addr;
        logic        push;
        logic        flush;
        logic        fv;
    } vec_t;

    vec_t vecs[$];

    ifu_fetch_ctrl #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (A)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_redirect_valid  (redir_v),
        .i_redirect_pc     (redir_pc),
        .o_imem_req_valid  (req_v),
        .i_imem_req_ready  (req_rdy),
        .o_imem_req_addr   (req_addr),
        .i_imem_resp_valid (resp_v),
        .i_imem_resp_data  (resp_d),
        .o_fifo_push       (push),
        .o_fifo_entry      (entry),
        .o_fifo_flush      (flush),
        .i_fifo_pop        (pop),
        .o_fifo_valid      (fvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic void addv(input logic rdy, input logic rv, input logic [31:0] raddr,
                                 input logic p, input logic rd, input logic [31:0] rpc,
                                 input logic v, input logic [31:0] addr, input logic ps,
                                 input logic fl, input logic fv);
        vec_t t;
        t.rdy = rdy; t.rv = rv; t.raddr = raddr; t.pop = p; t.redir = rd; t.rpc = rpc;
        t.v = v; t.addr = addr; t.push = ps; t.flush = fl; t.fv = fv;
        vecs.push_back(t);
    endfunction

    task automatic apply(input logic rdy, input logic rv, input logic [31:0] raddr,
                         input logic p, input logic rd, input logic [31:0] rpc);
        req_rdy  = rdy;
        resp_v   = rv;
        resp_d   = rv ? data_of(raddr) : 32'h0;
        pop      = p;
        redir_v  = rd;
        redir_pc = rpc;
    endtask

    // Compare settled outputs, then advance to just after the next rising edge
    task automatic check(input string name, input logic ev, input logic [31:0] eaddr,
                         input logic epush, input logic [31:0] eentry,
                         input logic eflush, input logic efv);
        logic [67:0] e;
        logic [67:0] a;
        #1;
        e = {ev, ev ? eaddr : 32'h0, epush, epush ? eentry : 32'h0, eflush, efv};
        a = {req_v, req_v ? req_addr : 32'h0, push, push ? entry : 32'h0, flush, fvalid};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got v/addr/push/entry/flush/fv=%h want %h", name, a, e);
        end
        if (int'(dut.r_fifo_cnt) > 4 || int'(dut.r_outst) > 2 || int'(dut.r_drop_cnt) > 2) begin
            bad++;
            $display("FAIL %s counter_range: fifo_cnt=%0d outst=%0d drop=%0d want <=4/2/2",
                     name, dut.r_fifo_cnt, dut.r_outst, dut.r_drop_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // C0..C26: fill, full credit, pop, redirect with drops, outstanding saturation
        addv(1,0,0,       0,0,0,         0,0,        0,0,0);
        addv(1,0,0,       0,0,0,         1,A,        0,0,0);
        addv(1,1,A,       0,0,0,         1,A+4,      1,0,0);
        addv(1,1,A+4,     0,0,0,         1,A+8,      1,0,1);
        addv(1,1,A+8,     0,0,0,         1,A+12,     1,0,1);
        addv(1,1,A+12,    0,0,0,         0,0,        1,0,1);
        addv(1,0,0,       0,0,0,         0,0,        0,0,1);
        addv(1,0,0,       1,0,0,         0,0,        0,0,1);
        addv(1,0,0,       0,0,0,         1,A+16,     0,0,1);
        addv(1,1,A+16,    0,0,0,         0,0,        1,0,1);
        addv(1,0,0,       1,0,0,         0,0,        0,0,1);
        addv(1,0,0,       1,0,0,         1,A+20,     0,0,1);
        addv(1,0,0,       0,0,0,         1,A+24,     0,0,1);
        addv(1,0,0,       0,1,32'h1000,  0,0,        0,0,0);
        addv(1,1,A+20,    0,0,0,         0,0,        0,1,0);
        addv(1,1,A+24,    0,0,0,         0,0,        0,0,0);
        addv(1,0,0,       0,0,0,         0,0,        0,0,0);
        addv(1,0,0,       0,0,0,         1,32'h1000, 0,0,0);
        addv(1,0,0,       0,0,0,         1,32'h1004, 0,0,0);
        addv(1,1,32'h1000,0,0,0,         0,0,        1,0,0);
        addv(1,1,32'h1004,0,0,0,         1,32'h1008, 1,0,1);
        addv(1,0,0,       0,0,0,         1,32'h100C, 0,0,1);
        addv(1,0,0,       1,0,0,         0,0,        0,0,1);
        addv(1,1,32'h1008,0,0,0,         0,0,        1,0,1);
        addv(1,0,0,       0,0,0,         1,32'h1010, 0,0,1);
        addv(1,1,32'h100C,0,0,0,         0,0,        1,0,1);
        addv(1,1,32'h1010,0,0,0,         0,0,        1,0,1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rdy, vecs[i].rv, vecs[i].raddr, vecs[i].pop, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].addr, vecs[i].push,
                  data_of(vecs[i].raddr), vecs[i].flush, vecs[i].fv);
        end

        // FIFO full; one pop frees a credit, then imem stalls for 5 cycles
        apply(1, 0, 0, 1, 0, 0);
        check("full_pop", 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 0, 0, 0, 0);
            check($sformatf("stall%0d", k), 1, 32'h1014, 0, 0, 0, 1);
        end
        apply(1, 0, 0, 0, 0, 0);
        check("stall_accept", 1, 32'h1014, 0, 0, 0, 1);
        apply(1, 1, 32'h1014, 1, 0, 0);
        check("stall_resp", 0, 0, 1, data_of(32'h1014), 0, 1);
        apply(1, 0, 0, 0, 0, 0);
        check("pc_once", 1, 32'h1018, 0, 0, 0, 1);

        // Reset with one request still outstanding
        apply(1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        check("pre_rst", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        check("post_rst", 0, 0, 0, 0, 0, 0);
        check("rst_first_req", 1, A, 0, 0, 0, 0);

        // Response arriving in the redirect cycle is dropped and not counted again
        apply(1, 1, A, 0, 1, 32'h2000);
        check("redir_resp_drop", 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check("redir_flush", 0, 0, 0, 0, 1, 0);
        check("redir_drain", 0, 0, 0, 0, 0, 0);
        check("redir_new_pc", 1, 32'h2000, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
